// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage: instruction geometry,
// class encodings, per-class dwell lengths and fetch FSM state encodings.
package instr_fetch_pkg;

    localparam int INSTR_WIDTH = 20;
    localparam int PC_BITS     = 5;
    localparam int STD_CYCLES  = 3;
    localparam int MEM_CYCLES  = 4;
    localparam int DWELL_BITS  = $clog2(MEM_CYCLES + 2);

    typedef enum logic [1:0] {
        CLS_HALT  = 2'b00,
        CLS_STD   = 2'b01,
        CLS_LOAD  = 2'b10,
        CLS_STORE = 2'b11
    } instr_cls_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_e;

    // Counter reload so that an instruction stays on the bus for its class's cycle
    // count; the first issue after start gets one extra cycle for the CU's exit from RESET.
    function automatic logic [DWELL_BITS-1:0] dwell_reload(input logic [1:0] cls,
                                                           input logic       first);
        int cycles;
        cycles = (cls == CLS_STD) ? STD_CYCLES : MEM_CYCLES;
        if (first) begin
            cycles = cycles + 1;
        end
        return DWELL_BITS'(cycles - 1);
    endfunction

endpackage

// File: rtl/instr_fetch_mem.sv
// Program memory: one synchronous write port and one registered read port, no reset,
// so it maps onto block RAM. A read one cycle after a write returns the new word.
module instr_fetch_mem #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 20
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];
    logic [DATA_BITS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds each instruction on the bus for exactly the cycles
// the control unit needs, prefetching the following word so issue is back-to-back.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prog_wen_i,
    input  logic [PC_BITS-1:0]     prog_addr_i,
    input  logic [INSTR_WIDTH-1:0] prog_data_i,
    input  logic                   start_i,
    output logic [INSTR_WIDTH-1:0] instruction_o,
    output logic [PC_BITS-1:0]     pc_o,
    output logic                   busy_o,
    output logic                   halted_o
);

    fetch_state_e           state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [INSTR_WIDTH-1:0] prefetch_q, prefetch_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [DWELL_BITS-1:0]  dwell_q, dwell_d;
    logic                   first_q, first_d;
    logic                   rd_pending_q, rd_pending_d;

    logic                   mem_we;
    logic [PC_BITS-1:0]     mem_raddr;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic [1:0]             rdata_cls;
    logic [1:0]             prefetch_cls;

    assign rdata_cls    = mem_rdata[INSTR_WIDTH-1 -: 2];
    assign prefetch_cls = prefetch_q[INSTR_WIDTH-1 -: 2];

    instr_fetch_mem #(
        .ADDR_BITS (PC_BITS),
        .DATA_BITS (INSTR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr_i),
        .wdata_i (prog_data_i),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            instr_q      <= '0;
            prefetch_q   <= '0;
            pc_q         <= '0;
            dwell_q      <= '0;
            first_q      <= 1'b1;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            prefetch_q   <= prefetch_d;
            pc_q         <= pc_d;
            dwell_q      <= dwell_d;
            first_q      <= first_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        prefetch_d   = prefetch_q;
        pc_d         = pc_q;
        dwell_d      = dwell_q;
        first_d      = first_q;
        rd_pending_d = rd_pending_q;
        mem_we       = 1'b0;
        mem_raddr    = pc_q + PC_BITS'(1);

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // Write and start may coincide; the write lands before the FETCH read.
                mem_we = prog_wen_i;
                if (start_i) begin
                    state_d      = ST_FETCH;
                    pc_d         = '0;
                    first_d      = 1'b1;
                    rd_pending_d = 1'b0;
                end
            end
            ST_FETCH: begin
                mem_raddr = pc_q;
                if (!rd_pending_q) begin
                    rd_pending_d = 1'b1;
                end else begin
                    rd_pending_d = 1'b0;
                    if (rdata_cls == CLS_HALT) begin
                        state_d = ST_HALT;
                        instr_d = '0;
                    end else begin
                        state_d = ST_ISSUE;
                        instr_d = mem_rdata;
                        dwell_d = dwell_reload(rdata_cls, first_q);
                        first_d = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                // Minimum dwell is 2, so the pc+1 read always lands before dwell reaches 0.
                if (dwell_q != '0) begin
                    dwell_d    = dwell_q - DWELL_BITS'(1);
                    prefetch_d = mem_rdata;
                end else if (prefetch_cls != CLS_HALT) begin
                    instr_d = prefetch_q;
                    pc_d    = pc_q + PC_BITS'(1);
                    dwell_d = dwell_reload(prefetch_cls, 1'b0);
                end else begin
                    instr_d = '0;
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign instruction_o = instr_q;
    assign pc_o          = pc_q;
    assign busy_o        = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
    assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, the reference program trace, halt/wrap at the
// end of memory, ignored controls while running, async reset mid-instruction, write+start.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        prog_wen;
    logic [4:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic [19:0] instruction;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;

    int n_checks;
    int n_fails;

    // Hand-derived trace of the reference program; sample 0 is the negedge right
    // after the edge that samples start.
    logic [19:0] exp_instr  [15];
    logic [4:0]  exp_pc     [15];
    logic        exp_busy   [15];
    logic        exp_halted [15];

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .prog_wen_i    (prog_wen),
        .prog_addr_i   (prog_addr),
        .prog_data_i   (prog_data),
        .start_i       (start),
        .instruction_o (instruction),
        .pc_o          (pc),
        .busy_o        (busy),
        .halted_o      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_word(input logic [4:0] addr, input logic [19:0] data);
        @(negedge clk);
        prog_wen  = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(negedge clk);
        prog_wen  = 1'b0;
    endtask

    task automatic load_reference;
        load_word(5'd0, 20'h5B000);
        load_word(5'd1, 20'h84030);
        load_word(5'd2, 20'hC4000);
        load_word(5'd3, 20'h00000);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (instruction !== 20'h0 || pc !== 5'd0 || busy !== 1'b0 || halted !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_hold: got instr=%h pc=%0d busy=%b halted=%b required 0/0/0/0",
                     instruction, pc, busy, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (instruction !== 20'h0 || pc !== 5'd0 || busy !== 1'b0 || halted !== 1'b0) begin
                n_fails++;
                $display("FAIL idle[%0d]: got instr=%h pc=%0d busy=%b halted=%b required 0/0/0/0",
                         c, instruction, pc, busy, halted);
            end
        end
        $display("test_reset: idle checked for 10 clocks");
    endtask

    task automatic test_program;
        load_reference();
        pulse_start();
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (instruction !== exp_instr[k] || pc !== exp_pc[k] ||
                busy !== exp_busy[k] || halted !== exp_halted[k]) begin
                n_fails++;
                $display("FAIL program[%0d]: got instr=%h pc=%0d busy=%b halted=%b required %h/%0d/%b/%b",
                         k, instruction, pc, busy, halted,
                         exp_instr[k], exp_pc[k], exp_busy[k], exp_halted[k]);
            end
        end
        $display("test_program: reference trace of 15 samples checked");
    endtask

    task automatic test_halt_at_end;
        int steps;
        for (int j = 0; j < 31; j++) begin
            load_word(5'(j), 20'h40000 | 20'(j));
        end
        load_word(5'd31, 20'h00000);
        pulse_start();
        steps = 0;
        while (halted !== 1'b1 && steps < 200) begin
            @(negedge clk);
            steps++;
        end
        // 2 fetch samples, 4 for word 0, 3 each for words 1..30
        n_checks++;
        if (steps !== 96) begin
            n_fails++;
            $display("FAIL halt_cycle: got halted at sample %0d required 96", steps);
        end
        n_checks++;
        if (pc !== 5'd30 || instruction !== 20'h0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL halt_state: got pc=%0d instr=%h busy=%b required 30/00000/0",
                     pc, instruction, busy);
        end
        $display("test_halt_at_end: halted after %0d samples", steps);
    endtask

    task automatic test_wrap;
        load_word(5'd31, 20'h4001F);
        pulse_start();
        for (int s = 1; s <= 98; s++) @(negedge clk);
        n_checks++;
        if (pc !== 5'd31 || instruction !== 20'h4001F || busy !== 1'b1) begin
            n_fails++;
            $display("FAIL wrap_last: got pc=%0d instr=%h busy=%b required 31/4001f/1",
                     pc, instruction, busy);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== 5'd0 || instruction !== 20'h40000 || busy !== 1'b1 || halted !== 1'b0) begin
            n_fails++;
            $display("FAIL wrap_first: got pc=%0d instr=%h busy=%b halted=%b required 0/40000/1/0",
                     pc, instruction, busy, halted);
        end
        for (int s = 0; s < 20; s++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || halted !== 1'b0) begin
            n_fails++;
            $display("FAIL wrap_busy: got busy=%b halted=%b required 1/0", busy, halted);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_wrap: pc wrapped 31 -> 0 while busy");
    endtask

    task automatic test_ignore_while_running;
        load_reference();
        pulse_start();
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 4) begin
                prog_wen = 1'b0;
                start    = 1'b0;
            end
            n_checks++;
            if (instruction !== exp_instr[k] || pc !== exp_pc[k] ||
                busy !== exp_busy[k] || halted !== exp_halted[k]) begin
                n_fails++;
                $display("FAIL ignore[%0d]: got instr=%h pc=%0d busy=%b halted=%b required %h/%0d/%b/%b",
                         k, instruction, pc, busy, halted,
                         exp_instr[k], exp_pc[k], exp_busy[k], exp_halted[k]);
            end
            if (k == 3) begin
                prog_wen  = 1'b1;
                prog_addr = 5'd1;
                prog_data = 20'hFFFFF;
                start     = 1'b1;
            end
        end
        $display("test_ignore_while_running: write and start during ISSUE had no effect");
    endtask

    task automatic test_reset_mid_load;
        pulse_start();
        for (int k = 1; k <= 7; k++) @(negedge clk);
        n_checks++;
        if (instruction !== 20'h84030 || pc !== 5'd1) begin
            n_fails++;
            $display("FAIL pre_reset: got instr=%h pc=%0d required 84030/1", instruction, pc);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (instruction !== 20'h0 || pc !== 5'd0 || busy !== 1'b0 || halted !== 1'b0) begin
            n_fails++;
            $display("FAIL async_reset: got instr=%h pc=%0d busy=%b halted=%b required 0/0/0/0",
                     instruction, pc, busy, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (instruction !== exp_instr[k] || pc !== exp_pc[k] ||
                busy !== exp_busy[k] || halted !== exp_halted[k]) begin
                n_fails++;
                $display("FAIL rerun[%0d]: got instr=%h pc=%0d busy=%b halted=%b required %h/%0d/%b/%b",
                         k, instruction, pc, busy, halted,
                         exp_instr[k], exp_pc[k], exp_busy[k], exp_halted[k]);
            end
        end
        $display("test_reset_mid_load: async clear and identical rerun checked");
    endtask

    task automatic test_write_with_start;
        @(negedge clk);
        prog_wen  = 1'b1;
        prog_addr = 5'd0;
        prog_data = 20'h4A001;
        start     = 1'b1;
        @(negedge clk);
        prog_wen  = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (instruction !== 20'h4A001 || pc !== 5'd0) begin
            n_fails++;
            $display("FAIL write_start: got instr=%h pc=%0d required 4a001/0", instruction, pc);
        end
        for (int k = 3; k <= 6; k++) @(negedge clk);
        n_checks++;
        if (instruction !== 20'h84030 || pc !== 5'd1) begin
            n_fails++;
            $display("FAIL write_start_next: got instr=%h pc=%0d required 84030/1", instruction, pc);
        end
        $display("test_write_with_start: same-cycle write to address 0 was fetched");
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        prog_wen  = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;

        for (int k = 0; k < 15; k++) begin
            exp_busy[k]   = (k < 14);
            exp_halted[k] = (k == 14);
            if (k < 2)        exp_instr[k] = 20'h00000;
            else if (k < 6)   exp_instr[k] = 20'h5B000;
            else if (k < 10)  exp_instr[k] = 20'h84030;
            else if (k < 14)  exp_instr[k] = 20'hC4000;
            else              exp_instr[k] = 20'h00000;
            if (k < 6)        exp_pc[k] = 5'd0;
            else if (k < 10)  exp_pc[k] = 5'd1;
            else              exp_pc[k] = 5'd2;
        end

        test_reset();
        test_program();
        test_halt_at_end();
        test_wrap();
        test_ignore_while_running();
        test_reset_mid_load();
        test_write_with_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
